// File: rtl/arith_pkg.sv
// Shared definitions for the pipelined arithmetic unit: opcode map and the
// status-bus bit order also consumed by the writeback stage.
package arith_pkg;

    localparam int unsigned OP_PASS_A     = 0;
    localparam int unsigned OP_INC_A      = 1;
    localparam int unsigned OP_DEC_A      = 2;
    localparam int unsigned OP_PASS_B     = 3;
    localparam int unsigned OP_INC_B      = 4;
    localparam int unsigned OP_DEC_B      = 5;
    localparam int unsigned OP_ADD        = 6;
    localparam int unsigned OP_ADDC       = 7;
    localparam int unsigned OP_SUB        = 8;
    localparam int unsigned OP_SUBB       = 9;
    localparam int unsigned OP_ACC        = 10;
    localparam int unsigned OP_CLR_ACC    = 11;
    localparam int unsigned OP_LAST_LEGAL = 11;

    // Status bus order: {E,V,N,Z,C} from MSB to LSB
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;
    localparam int FLAG_E = 4;
    localparam int FLAG_W = 5;

    typedef logic [FLAG_W-1:0] status_t;

endpackage

// File: rtl/arith_core.sv
// Combinational datapath of the arithmetic unit: operand routing, add/sub with
// carry/borrow and signed overflow, accumulator write request and illegal-op detect.
module arith_core
    import arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SEL_W = 4
) (
    input  logic [SEL_W-1:0] op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] res,
    output logic             carry,
    output logic             ovf,
    output logic             err,
    output logic             acc_we
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    int unsigned      op_n;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             ci;
    logic             is_add;
    logic             is_sub;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    // Every op is reduced to x (+|-) y (+|-) ci, or a plain pass of x
    always_comb begin
        op_n   = 32'(op);
        x      = '0;
        y      = '0;
        ci     = 1'b0;
        is_add = 1'b0;
        is_sub = 1'b0;
        acc_we = 1'b0;
        err    = (op_n > OP_LAST_LEGAL);
        case (op_n)
            OP_PASS_A:  x = a;
            OP_INC_A:   begin x = a;   y = ONE; is_add = 1'b1; end
            OP_DEC_A:   begin x = a;   y = ONE; is_sub = 1'b1; end
            OP_PASS_B:  x = b;
            OP_INC_B:   begin x = b;   y = ONE; is_add = 1'b1; end
            OP_DEC_B:   begin x = b;   y = ONE; is_sub = 1'b1; end
            OP_ADD:     begin x = a;   y = b;   is_add = 1'b1; end
            OP_ADDC:    begin x = a;   y = b;   ci = c_in; is_add = 1'b1; end
            OP_SUB:     begin x = a;   y = b;   is_sub = 1'b1; end
            OP_SUBB:    begin x = a;   y = b;   ci = c_in; is_sub = 1'b1; end
            OP_ACC:     begin x = acc; y = a;   is_add = 1'b1; acc_we = 1'b1; end
            OP_CLR_ACC: acc_we = 1'b1;
            default:    ;
        endcase
    end

    assign sum  = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
    assign diff = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, ci};

    always_comb begin
        res   = x;
        carry = 1'b0;
        ovf   = 1'b0;
        if (is_add) begin
            res   = sum[WIDTH-1:0];
            carry = sum[WIDTH];
            ovf   = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
        end else if (is_sub) begin
            res   = diff[WIDTH-1:0];
            carry = diff[WIDTH];
            ovf   = (x[WIDTH-1] != y[WIDTH-1]) && (diff[WIDTH-1] != x[WIDTH-1]);
        end
    end

endmodule

// File: rtl/arith_unit_pipe.sv
// Two-stage pipelined arithmetic unit with valid/ready on both sides; stage 1
// captures the beat, stage 2 computes and registers result, flags and accumulator.
module arith_unit_pipe
    import arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SEL_W-1:0] sel,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             carry,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             err
);

    logic             en;
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [SEL_W-1:0] s1_sel_q;
    logic             s1_cin_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] res_q;
    status_t          flags_q;
    status_t          flags_d;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;

    logic [WIDTH-1:0] core_res;
    logic             core_carry;
    logic             core_ovf;
    logic             core_err;
    logic             core_acc_we;

    // Whole pipeline advances together; a full output stage blocks both stages
    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    arith_core #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_core (
        .op     (s1_sel_q),
        .a      (s1_a_q),
        .b      (s1_b_q),
        .c_in   (s1_cin_q),
        .acc    (acc_q),
        .res    (core_res),
        .carry  (core_carry),
        .ovf    (core_ovf),
        .err    (core_err),
        .acc_we (core_acc_we)
    );

    always_comb begin
        flags_d         = '0;
        flags_d[FLAG_C] = core_carry;
        flags_d[FLAG_Z] = (core_res == '0);
        flags_d[FLAG_N] = core_res[WIDTH-1];
        flags_d[FLAG_V] = core_ovf;
        flags_d[FLAG_E] = core_err;
        acc_d           = core_acc_we ? core_res : acc_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_sel_q    <= '0;
            s1_cin_q    <= 1'b0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            flags_q     <= '0;
            acc_q       <= '0;
        end else if (en) begin
            s1_valid_q  <= in_valid;
            s1_a_q      <= a;
            s1_b_q      <= b;
            s1_sel_q    <= sel;
            s1_cin_q    <= c_in;
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                res_q   <= core_res;
                flags_q <= flags_d;
                acc_q   <= acc_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign carry     = flags_q[FLAG_C];
    assign zero      = flags_q[FLAG_Z];
    assign neg       = flags_q[FLAG_N];
    assign ovf       = flags_q[FLAG_V];
    assign err       = flags_q[FLAG_E];

endmodule

// File: tb/tb_arith_unit_pipe.sv
// Scoreboard bench for arith_unit_pipe: expected beats are queued at accept time
// from a plain-arithmetic reference model and popped by an independent output monitor.
module tb_arith_unit_pipe;

    localparam int W = 8;
    localparam int M = 2 ** W;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   sel;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic         carry, zero, neg, ovf, err;

    int errors = 0;
    int checks = 0;
    int model_acc = 0;
    logic [W+4:0] sb[$];
    logic [W+4:0] prev_vec;
    bit           stall_prev = 0;
    bit           done = 0;

    arith_unit_pipe #(.WIDTH(W), .SEL_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .carry     (carry),
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: operation result as mathematical integers, then wrapped to W bits.
    function automatic logic [W+4:0] model(int s, int av, int bv, int ci);
        int x = 0, y = 0, cc = 0, full, sx, sy, sfull, r;
        bit is_add = 0, is_sub = 0, e = 0, c, v;
        logic [W-1:0] rv;
        case (s)
            0:  x = av;
            1:  begin x = av; y = 1; is_add = 1; end
            2:  begin x = av; y = 1; is_sub = 1; end
            3:  x = bv;
            4:  begin x = bv; y = 1; is_add = 1; end
            5:  begin x = bv; y = 1; is_sub = 1; end
            6:  begin x = av; y = bv; is_add = 1; end
            7:  begin x = av; y = bv; cc = ci; is_add = 1; end
            8:  begin x = av; y = bv; is_sub = 1; end
            9:  begin x = av; y = bv; cc = ci; is_sub = 1; end
            10: begin x = model_acc; y = av; is_add = 1; end
            11: x = 0;
            default: e = 1;
        endcase
        sx = (x >= M / 2) ? x - M : x;
        sy = (y >= M / 2) ? y - M : y;
        full  = is_add ? x + y + cc : (is_sub ? x - y - cc : x);
        sfull = is_add ? sx + sy + cc : (is_sub ? sx - sy - cc : sx);
        r = ((full % M) + M) % M;
        c = is_add ? (full >= M) : (is_sub ? (full < 0) : 1'b0);
        v = (is_add || is_sub) && (sfull > M / 2 - 1 || sfull < -(M / 2));
        if (s == 10 || s == 11) model_acc = r;
        rv = W'(r);
        return {rv, c, (r == 0), rv[W-1], v, e};
    endfunction

    task automatic drive_beat(int s, int av, int bv, int ci);
        bit ok = 0;
        int guard = 0;
        while (!ok) begin
            @(negedge clk);
            in_valid = 1'b1;
            sel = 4'(s); a = W'(av); b = W'(bv); c_in = ci[0];
            #4;
            ok = in_ready;
            @(posedge clk);
            if (ok) sb.push_back(model(s, av, bv, ci));
            guard++;
            if (!ok && guard > 200) begin
                check("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", sb.size(), 0);
    endtask

    // Output monitor
    always @(negedge clk) begin
        logic [W+4:0] got;
        #3;
        got = {res, carry, zero, neg, ovf, err};
        if (rst_n !== 1'b1) begin
            stall_prev = 0;
        end else if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat got=%0h exp=none at %0t", got, $time);
            end else begin
                check("out_beat", 32'(got), 32'(sb.pop_front()));
            end
            stall_prev = 0;
        end else if (out_valid) begin
            if (stall_prev) check("stall_hold", 32'(got), 32'(prev_vec));
            stall_prev = 1;
            prev_vec = got;
        end else begin
            stall_prev = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; sel = 4'd10; a = 8'h55; b = 8'h00;
        c_in = 1'b0; out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk); #3;
            check("rst_out_valid", 32'(out_valid), 0);
            check("rst_res", 32'(res), 0);
        end
        rst_n = 1'b1; in_valid = 1'b0;

        // First beat reads acc, so a zero result also shows acc was cleared
        drive_beat(10, 0, 0, 0);
        @(negedge clk); in_valid = 1'b0; #3;
        check("lat_edge1", 32'(out_valid), 0);
        @(negedge clk); #3;
        check("lat_edge2", 32'(out_valid), 1);
        drain();

        drive_beat(7, 8'hFF, 8'h00, 1);
        drive_beat(8, 8'h80, 8'h01, 0);
        drive_beat(10, 5, 0, 0);
        drive_beat(10, 7, 0, 0);
        drive_beat(10, 8'hFA, 0, 0);
        drive_beat(11, 8'h12, 8'h34, 1);
        idle();
        drain();

        drive_beat(10, 8'h10, 0, 0);
        drive_beat(13, 8'h33, 8'h44, 1);
        drive_beat(10, 0, 0, 0);
        idle();
        drain();

        @(negedge clk); out_ready = 1'b0;
        fork
            begin
                drive_beat(6, 8'h7F, 8'h01, 0);
                drive_beat(8, 8'h00, 8'h01, 0);
                drive_beat(1, 8'hFF, 8'h00, 0);
                drive_beat(10, 8'h20, 8'h00, 0);
                idle();
            end
            begin
                repeat (3) @(negedge clk);
                #2 check("bp_in_ready", 32'(in_ready), 0);
                @(negedge clk);
                #2 check("bp_in_ready2", 32'(in_ready), 0);
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        @(negedge clk); out_ready = 1'b0;
        drive_beat(6, 8'h11, 8'h22, 0);
        drive_beat(10, 8'h21, 8'h00, 0);
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0;
        sb.delete();
        model_acc = 0;
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        #3 check("rst_mid_valid", 32'(out_valid), 0);
        @(negedge clk); #3;
        check("rst_mid_valid2", 32'(out_valid), 0);
        drive_beat(10, 0, 0, 0);
        idle();
        drain();

        fork
            begin
                while (!done) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 300; i++) begin
                    drive_beat($urandom_range(0, 15), $urandom_range(0, M - 1),
                               $urandom_range(0, M - 1), $urandom_range(0, 1));
                    if ($urandom_range(0, 4) == 0) idle();
                end
                idle();
                done = 1;
            end
        join
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arith_unit_pipe.md
Name: arith_unit_pipe

Overview:
- Parametrised, pipelined successor to the team's 8-bit registered arithmetic unit.
- Adds the following:
  - WIDTH generalisation.
  - Subtract and accumulate operations.
  - Carry/zero/negative/overflow status flags.
  - An illegal-opcode error flag instead of a simulation-only message.
  - A valid/ready handshake on both sides, with backpressure.
- Sits between the ALU operand-select logic and the result/writeback stage of the datapath.

Parameters:
WIDTH, 8, operand/result/accumulator width in bits (>=2)
SEL_W, 4, opcode width; opcodes 0-11 legal, all others illegal

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, synchronous, active-low
in_valid  input  1  operand/opcode beat is valid
in_ready  output  1  unit accepts a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sel  input  SEL_W  opcode
c_in  input  1  carry-in (op 7) / borrow-in (op 9)
out_valid  output  1  result beat is valid
out_ready  input  1  downstream accepts the result
res  output  WIDTH  result
carry  output  1  unsigned carry-out (add ops) / borrow-out (sub ops)
zero  output  1  res == 0
neg  output  1  res[WIDTH-1]
ovf  output  1  two's-complement overflow
err  output  1  opcode was illegal

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low: it is sampled only on a rising clk edge while low.
- Reset state: s1_valid=0, out_valid=0, res=0, all flags=0, accumulator acc=0.
- Reset mid-operation: in-flight beats are discarded and never appear at the output.
- Pipeline structure:
  - Stage 1 registers a, b, sel and c_in.
  - Stage 2 computes from the stage-1 registers (and acc), then registers res and the flags.
  - Latency is exactly 2 cycles from the in_valid&&in_ready edge to out_valid when there is no stall.
- Stall rule:
  - Advance enable en = !out_valid || out_ready.
  - in_ready = en, combinational; no dependence of in_ready on in_valid.
  - When en=0, both stages hold. res and all flags stay stable while out_valid && !out_ready.
  - A beat is accepted only when in_valid && in_ready. A bubble in stage 1 propagates out_valid=0.
- Opcodes (all arithmetic modulo 2^WIDTH):
  - 0: A
  - 1: A+1
  - 2: A-1
  - 3: B
  - 4: B+1
  - 5: B-1
  - 6: A+B
  - 7: A+B+c_in
  - 8: A-B
  - 9: A-B-c_in
  - 10: acc+A, with acc <= result
  - 11: clear, with res=0 and acc <= 0
- Flags:
  - carry: for add ops 1,4,6,7,10 it is bit WIDTH of the (WIDTH+1)-bit sum. For sub ops 2,5,8,9 it is 1 on unsigned underflow. It is 0 for ops 0,3,11.
  - ovf: signed overflow for add/sub ops, 0 otherwise.
  - zero and neg: derived from res for every legal op.
- Accumulator:
  - Updated only when an op-10 or op-11 beat moves into stage 2 (en=1).
  - Back-to-back op-10 beats chain without a hazard, because acc is read and written in the same stage.
- Illegal opcode (12-15): the beat still flows through with err=1, res=0 and carry/ovf/neg=0, zero=1; acc is unchanged. err=0 for every legal beat.
- Simultaneous accept and drain: when out_ready=1 with a full pipeline, throughput is 1 beat/cycle.

Decomposition:
- Package arith_pkg holds:
  - opcode localparams OP_PASS_A … OP_CLR_ACC and OP_LAST_LEGAL=11;
  - the flag bit order (C,Z,N,V,E) for the status bus, shared with the writeback stage.
- Sub-module arith_core is purely combinational. It takes (op, a, b, c_in, acc) and returns {res, carry, ovf, err, acc_we}. It is instantiated in stage 2.
- The pipeline registers and handshake stay in arith_unit_pipe.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, res=0, acc=0; the first out_valid occurs 2 cycles after the first post-reset accept.
- WIDTH=8, op 7, a=0xFF, b=0x00, c_in=1 -> 2 cycles later res=0x00, carry=1, zero=1, ovf=0. Op 8 with a=0x80, b=0x01 -> res=0x7F, carry=0, ovf=1, neg=0.
- Accumulate: ops 10(a=5), 10(a=7), 10(a=0xFA) back-to-back -> res 0x05, 0x0C, 0x06 with carry=1 on the third; then op 11 -> res=0, zero=1.
- Backpressure: issue 4 beats with out_ready=0 for 3 cycles:
  - in_ready drops once stage 2 and stage 1 are full;
  - res stays stable while stalled;
  - after release, all 4 results emerge in order with none lost or duplicated.
- Illegal: sel=13, a=0x33 -> err=1, res=0, zero=1; acc keeps its prior value (verify with a following op 10, a=0).
- Reset mid-stream: assert rst_n=0 for one edge while 2 beats are in flight -> neither beat appears; out_valid=0 and acc=0 on the next cycle.
